emac_tx_bank_ctrl: RTL and testbench

Ping-pong bank controller for the 768x32 Ethernet MAC TX buffer, which holds two 384-word banks. Tracks which bank the CPU/EMIF side may fill and which bank holds a committed frame. Streams committed frames word-by-word from the buffer read port to the MAC transmit interface, with backpressure. Sits between the EMIF register block, the TX dual-port RAM read port and the MAC TX engine, all in the MAC TX clock domain.

---
 rtl/emac_tx_pkg.sv | 42 ++++
 rtl/emac_tx_skid2.sv | 69 ++++++
 rtl/emac_tx_bank_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_emac_tx_bank_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/emac_tx_pkg.sv
// Shared types and constants for the EMAC TX ping-pong bank controller.
// Imported by the controller top and its output skid buffer.
package emac_tx_pkg;

  localparam int BANK_WORDS = 384;
  localparam int LEN_W      = 11;
  localparam int MAX_LEN    = 1536;
  localparam int AW         = 9;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } tx_bank_state_t;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [3:0]  be;
  } tx_word_t;

  // Byte enables of the last word, from the low bits of the frame length
  function automatic logic [3:0] len2be(input logic [1:0] lsb);
    logic [3:0] be;
    unique case (lsb)
      2'd0:    be = 4'b1111;
      2'd1:    be = 4'b0001;
      2'd2:    be = 4'b0011;
      default: be = 4'b0111;
    endcase
    return be;
  endfunction

  // Word count ceil(len/4); legal lengths never overflow the 11-bit add
  function automatic logic [AW-1:0] len2nw(input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] t;
    t = (len + LEN_W'(3)) >> 2;
    return AW'(t);
  endfunction

endpackage

// File: rtl/emac_tx_skid2.sv
// Two-entry output FIFO in front of the MAC TX interface.
// Soaks up the one-cycle RAM read latency when the MAC stalls.
module emac_tx_skid2
  import emac_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush_i,
  input  logic       push_i,
  input  tx_word_t   push_data_i,
  input  logic       pop_i,
  output logic       valid_o,
  output tx_word_t   head_o,
  output logic [1:0] cnt_o
);

  logic [1:0] cnt_q, cnt_d;
  tx_word_t   e0_q, e0_d;
  tx_word_t   e1_q, e1_d;

  // Next FIFO contents: flush wins, else shift on pop and append on push
  always_comb begin
    cnt_d = cnt_q;
    e0_d  = e0_q;
    e1_d  = e1_q;
    if (flush_i) begin
      cnt_d = 2'd0;
    end else begin
      unique case ({push_i, pop_i})
        2'b10: begin
          if (cnt_q == 2'd0) e0_d = push_data_i;
          else               e1_d = push_data_i;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          e0_d  = e1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            e0_d = push_data_i;
          end else begin
            e0_d = e1_q;
            e1_d = push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  // FIFO storage register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 2'd0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
    end
  end

  assign valid_o = (cnt_q != 2'd0);
  assign head_o  = valid_o ? e0_q : '0;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/emac_tx_bank_ctrl.sv
// Ping-pong bank controller for the EMAC TX buffer.
// Tracks CPU fill/commit per bank and streams committed frames to the MAC.
module emac_tx_bank_ctrl
  import emac_tx_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_commit_i,
  input  logic [LEN_W-1:0] cpu_len_i,
  output logic             wr_ram_sel_o,
  output logic             cpu_busy_o,
  output logic             cpu_err_o,
  output logic             ram_cer_o,
  output logic [AW-1:0]    ram_ar_o,
  output logic             rd_ram_sel_o,
  input  logic [31:0]      ram_qr_i,
  output logic [31:0]      mti_data_o,
  output logic             mti_valid_o,
  output logic             mti_sop_o,
  output logic             mti_eop_o,
  output logic [3:0]       mti_be_o,
  input  logic             mti_rdy_i,
  input  logic             tx_abort_i,
  output logic             tx_done_o
);

  tx_bank_state_t   state_q, state_d;
  logic [1:0]       bank_full_q, bank_full_d;
  logic [LEN_W-1:0] bank_len_q [2];
  logic [LEN_W-1:0] bank_len_d [2];
  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic             err_q, err_d;
  logic [AW-1:0]    ctr_q, ctr_d;
  logic [AW-1:0]    nw_q, nw_d;
  logic [3:0]       last_be_q, last_be_d;
  logic             infl_q, infl_d;
  logic             infl_sop_q, infl_sop_d;
  logic             infl_eop_q, infl_eop_d;
  logic [3:0]       infl_be_q, infl_be_d;

  logic             accept;
  logic             release_bank;
  logic             flush;
  logic             cer;
  logic             hs;
  logic             room;
  logic [2:0]       occ;
  logic [1:0]       skid_cnt;
  logic             skid_valid;
  tx_word_t         skid_head;
  tx_word_t         push_word;

  assign hs  = skid_valid & mti_rdy_i;
  // Entries that will be held once this cycle's pop and any in-flight word land
  assign occ  = {1'b0, skid_cnt} + {2'b0, infl_q} - {2'b0, hs};
  assign room = (occ < 3'd2);

  assign cpu_busy_o = &bank_full_q;
  assign accept = cpu_commit_i & ~cpu_busy_o &
                  (cpu_len_i != '0) &
                  (cpu_len_i <= LEN_W'(MAX_LEN));

  // Bank bookkeeping, read issue and FSM next state
  always_comb begin
    state_d      = state_q;
    bank_full_d  = bank_full_q;
    bank_len_d   = bank_len_q;
    wr_sel_d     = wr_sel_q;
    rd_sel_d     = rd_sel_q;
    ctr_d        = ctr_q;
    nw_d         = nw_q;
    last_be_d    = last_be_q;
    infl_d       = 1'b0;
    infl_sop_d   = infl_sop_q;
    infl_eop_d   = infl_eop_q;
    infl_be_d    = infl_be_q;
    err_d        = cpu_commit_i & ~accept;
    release_bank = 1'b0;
    flush        = 1'b0;
    cer          = 1'b0;
    tx_done_o    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bank_full_q[rd_sel_q]) begin
          nw_d      = len2nw(bank_len_q[rd_sel_q]);
          last_be_d = len2be(bank_len_q[rd_sel_q][1:0]);
          ctr_d     = '0;
          state_d   = STREAM;
        end
      end
      STREAM: begin
        if (tx_abort_i) begin
          release_bank = 1'b1;
          flush        = 1'b1;
          state_d      = IDLE;
        end else begin
          if ((ctr_q < nw_q) && room) begin
            cer        = 1'b1;
            ctr_d      = ctr_q + AW'(1);
            infl_d     = 1'b1;
            infl_sop_d = (ctr_q == '0);
            infl_eop_d = (ctr_q == nw_q - AW'(1));
            infl_be_d  = infl_eop_d ? last_be_q : 4'b1111;
          end
          if (hs && skid_head.eop) state_d = DONE;
        end
      end
      DONE: begin
        release_bank = 1'b1;
        flush        = tx_abort_i;
        tx_done_o    = ~tx_abort_i;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (release_bank) begin
      bank_full_d[rd_sel_q] = 1'b0;
      rd_sel_d              = ~rd_sel_q;
    end
    if (accept) begin
      bank_full_d[wr_sel_q] = 1'b1;
      bank_len_d[wr_sel_q]  = cpu_len_i;
      wr_sel_d              = ~wr_sel_q;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      bank_full_q   <= 2'b00;
      bank_len_q[0] <= '0;
      bank_len_q[1] <= '0;
      wr_sel_q      <= 1'b0;
      rd_sel_q      <= 1'b0;
      err_q         <= 1'b0;
      ctr_q         <= '0;
      nw_q          <= '0;
      last_be_q     <= 4'b0000;
      infl_q        <= 1'b0;
      infl_sop_q    <= 1'b0;
      infl_eop_q    <= 1'b0;
      infl_be_q     <= 4'b0000;
    end else begin
      state_q       <= state_d;
      bank_full_q   <= bank_full_d;
      bank_len_q    <= bank_len_d;
      wr_sel_q      <= wr_sel_d;
      rd_sel_q      <= rd_sel_d;
      err_q         <= err_d;
      ctr_q         <= ctr_d;
      nw_q          <= nw_d;
      last_be_q     <= last_be_d;
      infl_q        <= infl_d;
      infl_sop_q    <= infl_sop_d;
      infl_eop_q    <= infl_eop_d;
      infl_be_q     <= infl_be_d;
    end
  end

  assign push_word = '{data: ram_qr_i, sop: infl_sop_q,
                       eop: infl_eop_q, be: infl_be_q};

  emac_tx_skid2 u_skid (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .push_i      (infl_q & ~flush),
    .push_data_i (push_word),
    .pop_i       (hs),
    .valid_o     (skid_valid),
    .head_o      (skid_head),
    .cnt_o       (skid_cnt)
  );

  assign wr_ram_sel_o = wr_sel_q;
  assign rd_ram_sel_o = rd_sel_q;
  assign cpu_err_o    = err_q;
  assign ram_cer_o    = cer;
  assign ram_ar_o     = cer ? ctr_q : '0;
  assign mti_valid_o  = skid_valid;
  assign mti_data_o   = skid_head.data;
  assign mti_sop_o    = skid_head.sop;
  assign mti_eop_o    = skid_head.eop;
  assign mti_be_o     = skid_head.be;

endmodule

// File: tb/tb_emac_tx_bank_ctrl.sv
// Randomised bench for emac_tx_bank_ctrl against a frame-queue model.
// RAM contents are random; each accepted word is checked against them.
module tb_emac_tx_bank_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_commit_i;
  logic [10:0] cpu_len_i;
  logic        wr_ram_sel_o;
  logic        cpu_busy_o;
  logic        cpu_err_o;
  logic        ram_cer_o;
  logic [8:0]  ram_ar_o;
  logic        rd_ram_sel_o;
  logic [31:0] ram_qr_i;
  logic [31:0] mti_data_o;
  logic        mti_valid_o;
  logic        mti_sop_o;
  logic        mti_eop_o;
  logic [3:0]  mti_be_o;
  logic        mti_rdy_i;
  logic        tx_abort_i;
  logic        tx_done_o;

  emac_tx_bank_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_commit_i (cpu_commit_i),
    .cpu_len_i    (cpu_len_i),
    .wr_ram_sel_o (wr_ram_sel_o),
    .cpu_busy_o   (cpu_busy_o),
    .cpu_err_o    (cpu_err_o),
    .ram_cer_o    (ram_cer_o),
    .ram_ar_o     (ram_ar_o),
    .rd_ram_sel_o (rd_ram_sel_o),
    .ram_qr_i     (ram_qr_i),
    .mti_data_o   (mti_data_o),
    .mti_valid_o  (mti_valid_o),
    .mti_sop_o    (mti_sop_o),
    .mti_eop_o    (mti_eop_o),
    .mti_be_o     (mti_be_o),
    .mti_rdy_i    (mti_rdy_i),
    .tx_abort_i   (tx_abort_i),
    .tx_done_o    (tx_done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bank;
    int len;
  } frm_t;

  frm_t        q[$];
  logic [31:0] mem [768];
  int          cyc = 0;
  int          n_pass = 0;
  int          n_chk = 0;
  int          wr_m = 0;
  int          widx = 0;
  int          ridx = 0;
  int          done_cnt = 0;
  int          commit_cyc, cer0_cyc, sop_cyc, sophs_cyc, eop_cyc;
  int          last_done_cyc = 0;
  int          prev_done_cyc = 0;
  bit          seen_cer = 0;
  bit          seen_sop = 0;
  bit          pstall = 0;
  logic [31:0] pdata;
  logic [5:0]  pflags;

  always @(posedge clk) cyc <= cyc + 1;

  // Buffer RAM: registered read, garbage when not enabled
  always @(posedge clk) begin
    if (ram_cer_o)
      ram_qr_i <= mem[int'(rd_ram_sel_o) * 384 + int'(ram_ar_o)];
    else
      ram_qr_i <= $urandom;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int nwords(input int len);
    return (len + 3) / 4;
  endfunction

  function automatic logic [3:0] lastbe(input int len);
    int r;
    r = len % 4;
    if (r == 0) return 4'b1111;
    return 4'((1 << r) - 1);
  endfunction

  // Monitor: reads, accepted words and done pulses against the frame queue
  always @(negedge clk) begin
    int n;
    int base;
    if (rst) begin
      pstall = 0;
    end else begin
      if (pstall) begin
        check("hold_valid", mti_valid_o, 1);
        check("hold_data", mti_data_o, pdata);
        check("hold_flags", {mti_sop_o, mti_eop_o, mti_be_o}, pflags);
      end
      if (ram_cer_o) begin
        if (q.size() == 0) check("read_unexpected", 1, 0);
        else begin
          if (!seen_cer) begin cer0_cyc = cyc; seen_cer = 1; end
          check("read_addr", ram_ar_o, ridx);
          check("read_bank", rd_ram_sel_o, q[0].bank);
          ridx++;
        end
      end
      if (mti_valid_o && !seen_sop) begin sop_cyc = cyc; seen_sop = 1; end
      if (mti_valid_o && mti_rdy_i) begin
        if (q.size() == 0) check("word_unexpected", 1, 0);
        else begin
          n = nwords(q[0].len);
          base = q[0].bank * 384;
          if (widx >= n) check("word_overrun", widx, n - 1);
          else begin
            check("word_data", mti_data_o, mem[base + widx]);
            check("word_sop", mti_sop_o, widx == 0);
            check("word_eop", mti_eop_o, widx == n - 1);
            check("word_be", mti_be_o,
                  (widx == n - 1) ? lastbe(q[0].len) : 4'b1111);
          end
          if (widx == 0) sophs_cyc = cyc;
          if (mti_eop_o) eop_cyc = cyc;
          widx++;
        end
      end
      if (tx_done_o) begin
        if (q.size() == 0) check("done_unexpected", 1, 0);
        else begin
          n = nwords(q[0].len);
          check("done_words", widx, n);
          check("done_reads", ridx, n);
          check("done_latency", cyc, eop_cyc + 1);
          void'(q.pop_front());
        end
        widx = 0;
        ridx = 0;
        seen_cer = 0;
        seen_sop = 0;
        done_cnt++;
        prev_done_cyc = last_done_cyc;
        last_done_cyc = cyc;
      end
      pstall = mti_valid_o && !mti_rdy_i && !tx_abort_i;
      pdata  = mti_data_o;
      pflags = {mti_sop_o, mti_eop_o, mti_be_o};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    q.delete();
    wr_m = 0;
    widx = 0;
    ridx = 0;
    seen_cer = 0;
    seen_sop = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    cpu_commit_i = 0;
    tx_abort_i = 0;
    tick();
    check("rst_data", mti_data_o, 0);
    check("rst_outs", {wr_ram_sel_o, cpu_busy_o, cpu_err_o, ram_cer_o,
                       ram_ar_o, rd_ram_sel_o, mti_valid_o, mti_sop_o,
                       mti_eop_o, mti_be_o, tx_done_o}, 0);
    clear_model();
    tick();
    rst = 0;
  endtask

  task automatic commit(input int len);
    bit acc;
    acc = (q.size() < 2) && (len >= 1) && (len <= 1536);
    commit_cyc = cyc;
    cpu_commit_i = 1;
    cpu_len_i = 11'(len);
    if (acc) begin
      q.push_back('{bank: wr_m, len: len});
      wr_m ^= 1;
    end
    tick();
    cpu_commit_i = 0;
    check("commit_err", cpu_err_o, !acc);
    check("commit_wr_sel", wr_ram_sel_o, wr_m);
    check("commit_busy", cpu_busy_o, q.size() == 2);
  endtask

  task automatic drain(input int lim, input bit rnd);
    for (int i = 0; i < lim && q.size() != 0; i++) begin
      mti_rdy_i = rnd ? 1'($urandom % 2) : 1'b1;
      tick();
    end
    mti_rdy_i = 1;
    check("drain_timeout", q.size(), 0);
    tick();
  endtask

  initial begin
    int d0;
    for (int i = 0; i < 768; i++) mem[i] = $urandom;
    mti_rdy_i = 1;
    cpu_len_i = 0;
    do_reset();

    // Single 64-byte frame at full rate
    d0 = done_cnt;
    commit(64);
    drain(200, 0);
    check("t1_done_cnt", done_cnt, d0 + 1);
    check("t1_first_read", cer0_cyc - commit_cyc, 2);
    check("t1_first_valid", sop_cyc - cer0_cyc, 2);
    check("t1_full_rate", eop_cyc - sophs_cyc, 15);
    check("t1_rd_sel", rd_ram_sel_o, 1);

    // Back-to-back 61 and 1 byte frames
    commit(61);
    commit(1);
    drain(200, 0);
    check("t2_gap", cer0_cyc - prev_done_cyc, 2);

    // Length rejects, then fill both banks with the MAC stalled
    commit(0);
    commit(1537);
    mti_rdy_i = 0;
    commit(100);
    commit(200);
    commit(300);
    repeat (6) tick();
    check("t3_busy", cpu_busy_o, 1);
    drain(400, 0);

    // Max frame with random backpressure
    d0 = done_cnt;
    commit(1536);
    drain(3000, 1);
    check("t4_done_cnt", done_cnt, d0 + 1);

    // Abort at word 5 of a bank-0 frame with bank 1 full
    do_reset();
    d0 = done_cnt;
    commit(100);
    commit(40);
    for (int i = 0; i < 100 && widx < 5; i++) tick();
    check("t5_reach_word5", widx, 5);
    mti_rdy_i = 0;
    tx_abort_i = 1;
    tick();
    tx_abort_i = 0;
    mti_rdy_i = 1;
    void'(q.pop_front());
    widx = 0;
    ridx = 0;
    seen_cer = 0;
    seen_sop = 0;
    check("t5_busy", cpu_busy_o, 0);
    check("t5_rd_sel", rd_ram_sel_o, 1);
    check("t5_valid", mti_valid_o, 0);
    drain(200, 0);
    check("t5_done_cnt", done_cnt, d0 + 1);

    // Reset in the middle of a frame
    commit(200);
    for (int i = 0; i < 100 && widx < 3; i++) tick();
    check("t6_reach_word3", widx, 3);
    do_reset();
    check("t6_busy", cpu_busy_o, 0);
    d0 = done_cnt;
    commit(8);
    drain(100, 0);
    check("t6_done_cnt", done_cnt, d0 + 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
